// File: rtl/main_memory_unit.sv
// Line-organised backing store: 512-bit line fills, 32-bit word stores, fixed latency.
// Optional MAIN_MEM_STATS_EN adds saturating read/write completion counters.
module main_memory_unit #(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4,
    parameter int LINE_BITS   = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic                 mem_read_req,
    input  logic                 mem_write_req,
    output logic [LINE_BITS-1:0] mem_rdata,
    output logic                 mem_ready,
    output logic                 busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [3:0]           word_q;
    logic [31:0]          wdata_q;
    logic                 op_wr_q;
    logic [LINE_BITS-1:0] rdata_q;
    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    logic req;
    logic last_busy;
    logic commit;
    logic unused_addr_bits;

    assign req       = mem_read_req | mem_write_req;
    assign last_busy = (cnt_q == CNT_W'(LATENCY));
    assign commit    = (state_q == BUSY) && last_busy;

    // Byte-offset bits and bits above the line index are ignored; the index wraps.
    assign unused_addr_bits = ^{mem_addr[31:6+IDX_W], mem_addr[1:0]};

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) state_d = BUSY;
            end
            BUSY: begin
                if (last_busy) state_d = DONE;
                else           cnt_d   = cnt_q + CNT_W'(1);
            end
            DONE:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Request fields are captured once in IDLE; later request changes have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                idx_q   <= mem_addr[6+IDX_W-1:6];
                word_q  <= mem_addr[5:2];
                wdata_q <= mem_wdata;
                op_wr_q <= ~mem_read_req;
            end
            if (commit && !op_wr_q) rdata_q <= mem_q[idx_q];
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_n and only commits change them.
    always_ff @(posedge clk) begin
        if (commit && op_wr_q) mem_q[idx_q][{word_q, 5'b0} +: 32] <= wdata_q;
    end

    assign mem_rdata = rdata_q;

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == DONE) begin
            if (!op_wr_q && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
            if (op_wr_q && wr_count_q != 16'hFFFF)  wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_main_memory_unit.sv
// Directed bench for main_memory_unit: latency, read/write data, reset abort, priority, wrap.
module tb_main_memory_unit;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_read_req;
    logic         mem_write_req;
    logic [511:0] mem_rdata;
    logic         mem_ready;
    logic         busy;
`ifdef MAIN_MEM_STATS_EN
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    main_memory_unit #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .busy          (busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count      (rd_count),
        .wr_count      (wr_count)
`endif
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [511:0] init_line(input int idx);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'(idx * 64 + k * 4);
        return l;
    endfunction

    task automatic idle_wait();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        if (busy) begin
            total_cnt++;
            $error("FAIL idle_timeout: busy stayed high, got 1 expected 0");
        end
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!mem_ready && cycles < 50);
        if (!mem_ready) begin
            total_cnt++;
            $error("FAIL ready_timeout: mem_ready got 0 expected 1");
        end
    endtask

    // Issue one request from IDLE, wait for completion, drop the request.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int cycles);
        idle_wait();
        mem_read_req  = rd;
        mem_write_req = wr;
        mem_addr      = addr;
        mem_wdata     = data;
        wait_ready(cycles);
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
    endtask

    initial begin
        int           cyc;
        int           pulses;
        logic [511:0] exp_line;

        rst_n         = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) dut.mem_q[i] = init_line(i);

        #12;
        check("reset_ready", 512'(mem_ready), 512'(0));
        check("reset_busy", 512'(busy), 512'(0));
        check("reset_rdata", mem_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a write abandons it.
        idle_wait();
        mem_write_req = 1'b1;
        mem_addr      = 32'h40;
        mem_wdata     = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 512'(busy), 512'(1));
        #1 rst_n = 1'b0;
        mem_write_req = 1'b0;
        #1;
        check("abort_busy_in_reset", 512'(busy), 512'(0));
        check("abort_ready_in_reset", 512'(mem_ready), 512'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("abort_no_pulse", 512'(pulses), 512'(0));
        access(1'b1, 1'b0, 32'h40, '0, cyc);
        check("abort_word1", 512'(mem_rdata[63:32]), 512'(32'h44));
        check("abort_line", mem_rdata, init_line(1));

        // Read latency and pulse shape.
        access(1'b1, 1'b0, 32'h1000, '0, cyc);
        check("read_latency", 512'(cyc), 512'(LAT + 2));
        check("read_1000_line", mem_rdata, init_line(64));
        @(negedge clk);
        check("ready_one_cycle", 512'(mem_ready), 512'(0));
        check("gap_busy", 512'(busy), 512'(1));
        @(negedge clk);
        check("idle_after_gap", 512'(busy), 512'(0));

        // Address changes while busy are ignored.
        idle_wait();
        mem_read_req = 1'b1;
        mem_addr     = 32'h1C0;
        @(negedge clk);
        mem_addr = 32'h2000;
        wait_ready(cyc);
        mem_read_req = 1'b0;
        check("latched_addr", mem_rdata, init_line(7));

        // Word write, rdata hold, read-back.
        access(1'b0, 1'b1, 32'h2008, 32'hDEADBEEF, cyc);
        check("write_latency", 512'(cyc), 512'(LAT + 2));
        check("rdata_hold_on_write", mem_rdata, init_line(7));
        access(1'b1, 1'b0, 32'h2000, '0, cyc);
        exp_line         = init_line(128);
        exp_line[95:64]  = 32'hDEADBEEF;
        check("write_readback", mem_rdata, exp_line);

        // Simultaneous requests: read first, write after GAP.
        idle_wait();
        mem_read_req  = 1'b1;
        mem_write_req = 1'b1;
        mem_addr      = 32'h3000;
        mem_wdata     = 32'h12345678;
        pulses        = 0;
        wait_ready(cyc);
        if (mem_ready) pulses++;
        check("both_read_first", mem_rdata, init_line(192));
        mem_read_req = 1'b0;
        wait_ready(cyc);
        if (mem_ready) pulses++;
        mem_write_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("both_two_pulses", 512'(pulses), 512'(2));
        access(1'b1, 1'b0, 32'h3000, '0, cyc);
        exp_line        = init_line(192);
        exp_line[31:0]  = 32'h12345678;
        check("both_write_landed", mem_rdata, exp_line);

        // Wrap-around, ignored low bits, last line.
        access(1'b1, 1'b0, 32'h1000 + 32'(64 * DEPTH) + 32'd3, '0, cyc);
        check("wrap_read", mem_rdata, init_line(64));
        access(1'b1, 1'b0, 32'(64 * (DEPTH - 1)), '0, cyc);
        check("last_line", mem_rdata, init_line(DEPTH - 1));

`ifdef MAIN_MEM_STATS_EN
        idle_wait();
        rst_n = 1'b0;
        #1;
        check("stats_reset_rd", 512'(rd_count), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 1'b0, 32'h0, '0, cyc);
        access(1'b0, 1'b1, 32'h4, 32'h1, cyc);
        access(1'b1, 1'b0, 32'h40, '0, cyc);
        access(1'b0, 1'b1, 32'h44, 32'h2, cyc);
        access(1'b1, 1'b0, 32'h80, '0, cyc);
        idle_wait();
        check("stats_rd_count", 512'(rd_count), 512'(3));
        check("stats_wr_count", 512'(wr_count), 512'(2));
        dut.rd_count_q = 16'hFFFF;
        access(1'b1, 1'b0, 32'h0, '0, cyc);
        idle_wait();
        check("stats_saturate", 512'(rd_count), 512'(16'hFFFF));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
